// File: rtl/mpu_pkg.sv
// Shared MPU constants and the result-streamer state type.
package mpu_pkg;
  localparam int unsigned ELEM_W    = 8;
  localparam int unsigned DIM       = 5;
  localparam int unsigned MATRIX_W  = ELEM_W * DIM * DIM;
  localparam int unsigned NUM_ELEMS = DIM * DIM;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } mpu_state_e;
endpackage

// File: rtl/mpu_result_streamer_if.sv
// Matrix-in / element-stream-out handshake bundle for mpu_result_streamer.
interface mpu_result_streamer_if #(
  parameter int unsigned ELEM_W = mpu_pkg::ELEM_W,
  parameter int unsigned DIM    = mpu_pkg::DIM
);
  logic                           in_valid;
  logic                           in_ready;
  logic [ELEM_W*DIM*DIM-1:0]      in_matrix;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [ELEM_W-1:0]       out_data;
  logic [mpu_pkg::IDX_W-1:0]      out_col;
  logic [mpu_pkg::IDX_W-1:0]      out_row;
  logic                           out_last;
  logic                           busy;

  modport master (
    output in_valid, in_matrix, out_ready,
    input  in_ready, out_valid, out_data, out_col, out_row, out_last, busy
  );

  modport slave (
    input  in_valid, in_matrix, out_ready,
    output in_ready, out_valid, out_data, out_col, out_row, out_last, busy
  );
endinterface

// File: rtl/mpu_index_counter.sv
// (col,row) mod-DIM index counter, row fastest; clear has priority over enable.
module mpu_index_counter
  import mpu_pkg::*;
#(
  parameter int unsigned DIM_P = mpu_pkg::DIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] col_o,
  output logic [IDX_W-1:0] row_o,
  output logic             last_o
);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DIM_P - 1);

  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (row_q == MAX_IDX) begin
        row_d = '0;
        col_d = (col_q == MAX_IDX) ? '0 : col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == MAX_IDX) && (row_q == MAX_IDX);
endmodule

// File: rtl/mpu_result_streamer.sv
// Captures a DIMxDIM signed matrix and streams it one element per beat,
// row index fastest, with back-to-back matrix capture on the final beat.
module mpu_result_streamer #(
  parameter int unsigned ELEM_W = mpu_pkg::ELEM_W,
  parameter int unsigned DIM    = mpu_pkg::DIM
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ELEM_W*DIM*DIM-1:0]     in_matrix,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ELEM_W-1:0]      out_data,
  output logic [mpu_pkg::IDX_W-1:0]     out_col,
  output logic [mpu_pkg::IDX_W-1:0]     out_row,
  output logic                          out_last,
  output logic                          busy
);
  import mpu_pkg::*;

  localparam int unsigned MAT_W   = ELEM_W * DIM * DIM;
  localparam int unsigned N_ELEMS = DIM * DIM;
  localparam int unsigned SEL_W   = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;

  mpu_state_e         state_q, state_d;
  logic [MAT_W-1:0]   matrix_q, matrix_d;
  logic [IDX_W-1:0]   col, row;
  logic               cnt_last;
  logic               stream, beat_hs, capture, cnt_clear;
  logic [SEL_W-1:0]   elem_idx;
  logic [ELEM_W-1:0]  elems [N_ELEMS];

  mpu_index_counter #(
    .DIM_P (DIM)
  ) u_idx (
    .clk     (clock),
    .rst     (reset),
    .clear_i (cnt_clear),
    .en_i    (beat_hs),
    .col_o   (col),
    .row_o   (row),
    .last_o  (cnt_last)
  );

  // in_ready reopens only on the final-beat handshake so a waiting matrix
  // is captured in the same cycle, giving gapless back-to-back streams.
  always_comb begin
    stream    = (state_q == ST_STREAM);
    beat_hs   = stream && out_ready;
    in_ready  = !stream || (cnt_last && out_ready);
    capture   = in_valid && in_ready;
    cnt_clear = capture || (beat_hs && cnt_last);
    out_valid = stream;
    busy      = stream;
    out_last  = stream && cnt_last;
    out_col   = col;
    out_row   = row;
  end

  always_comb begin
    state_d  = state_q;
    matrix_d = matrix_q;
    unique case (state_q)
      ST_IDLE:   if (capture) state_d = ST_STREAM;
      ST_STREAM: if (beat_hs && cnt_last) state_d = capture ? ST_STREAM : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (capture) matrix_d = in_matrix;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      matrix_q <= '0;
    end else begin
      state_q  <= state_d;
      matrix_q <= matrix_d;
    end
  end

  for (genvar g = 0; g < N_ELEMS; g++) begin : g_elem
    assign elems[g] = matrix_q[g*ELEM_W +: ELEM_W];
  end

  always_comb begin
    elem_idx = SEL_W'(row) + SEL_W'(DIM) * SEL_W'(col);
    out_data = stream ? elems[elem_idx] : '0;
  end
endmodule
